// File: rtl/bcd_time_counter_pkg.sv
// bcd_time_counter_pkg: shared BCD field widths, limits, time struct and helpers
package bcd_time_counter_pkg;
  localparam int BCD_W = 8;
  localparam logic [BCD_W-1:0] SEC_MAX = 8'h59;
  localparam logic [BCD_W-1:0] MIN_MAX = 8'h59;
  typedef struct packed {
    logic [BCD_W-1:0] hour;
    logic [BCD_W-1:0] min;
    logic [BCD_W-1:0] sec;
  } time_t;
  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  function automatic logic bcd_ok(input logic [BCD_W-1:0] v, input logic [BCD_W-1:0] max);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v <= max;
  endfunction
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD modulo counter with load and carry-out
module bcd_mod_counter
  import bcd_time_counter_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = 8'h59
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_value,
  output logic [BCD_W-1:0] o_value,
  output logic             o_carry
);
  logic [BCD_W-1:0] nxt;
  assign o_carry = i_en && o_value == MAX;
  assign nxt = o_value == MAX ? '0 :
               o_value[3:0] == 4'd9 ? {o_value[7:4] + 4'd1, 4'd0} :
               {o_value[7:4], o_value[3:0] + 4'd1};
  always_ff @(posedge i_clk)
    if (i_rst) o_value <= '0;
    else if (i_load) o_value <= i_value;
    else if (i_en) o_value <= nxt;
endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: synchronized 1 Hz tick edge drives a 24-hour BCD HH:MM:SS counter
module bcd_time_counter
  import bcd_time_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOUR_MAX = 23
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_run,
  input  logic                 i_load,
  input  logic [3*BCD_W-1:0]   i_load_value,
  output logic [BCD_W-1:0]     o_sec,
  output logic [BCD_W-1:0]     o_min,
  output logic [BCD_W-1:0]     o_hour,
  output logic                 o_sec_pulse,
  output logic                 o_day_wrap,
  output logic                 o_load_err
);
  localparam logic [BCD_W-1:0] HOUR_BCD = to_bcd(HOUR_MAX);
  logic [SYNC_STAGES-1:0] sync, vld;
  logic hist, armed, sync_out, rise, tick_en, load_ok, load_en, sec_c, min_c, hour_c;
  time_t lv;
  assign lv = i_load_value;
  assign sync_out = sync[SYNC_STAGES-1];
  assign rise = sync_out && !hist && armed;
  assign tick_en = rise && i_run && !i_load;
  assign load_ok = bcd_ok(lv.sec, SEC_MAX) && bcd_ok(lv.min, MIN_MAX) && bcd_ok(lv.hour, HOUR_BCD);
  assign load_en = i_load && load_ok;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      sync <= '0;
      vld <= '0;
      hist <= 1'b0;
      armed <= 1'b0;
      o_sec_pulse <= 1'b0;
      o_day_wrap <= 1'b0;
      o_load_err <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_tick};
      vld <= {vld[SYNC_STAGES-2:0], 1'b1};
      hist <= sync_out;
      armed <= armed || (vld[SYNC_STAGES-1] && !sync_out);
      o_sec_pulse <= tick_en;
      o_day_wrap <= hour_c;
      o_load_err <= i_load && !load_ok;
    end
  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(tick_en), .i_load(load_en),
    .i_value(lv.sec), .o_value(o_sec), .o_carry(sec_c)
  );
  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(sec_c), .i_load(load_en),
    .i_value(lv.min), .o_value(o_min), .o_carry(min_c)
  );
  bcd_mod_counter #(.MAX(HOUR_BCD)) u_hour (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(min_c), .i_load(load_en),
    .i_value(lv.hour), .o_value(o_hour), .o_carry(hour_c)
  );
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: scoreboard bench for the BCD time-of-day counter
module tb_bcd_time_counter;
  localparam int SS = 2;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, run = 1'b0, load = 1'b0;
  logic [23:0] load_value = '0;
  logic [7:0] o_sec, o_min, o_hour;
  logic o_sec_pulse, o_day_wrap, o_load_err;
  logic [23:0] now;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [23:0] t;
    logic wrap;
    logic err;
    int at;
  } exp_t;
  exp_t q[$];
  exp_t e;
  bcd_time_counter #(.SYNC_STAGES(SS), .HOUR_MAX(23)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_run(run), .i_load(load),
    .i_load_value(load_value), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_sec_pulse(o_sec_pulse), .o_day_wrap(o_day_wrap), .o_load_err(o_load_err)
  );
  assign now = {o_hour, o_min, o_sec};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (!rst && (o_sec_pulse || o_day_wrap || o_load_err)) begin
      if (q.size() == 0) cmp("unexpected_event", {29'd0, o_sec_pulse, o_day_wrap, o_load_err}, 32'd0);
      else begin
        e = q.pop_front();
        cmp("event_time", {8'd0, now}, {8'd0, e.t});
        cmp("event_pulses", {29'd0, o_sec_pulse, o_day_wrap, o_load_err}, {29'd0, !e.err, e.wrap, e.err});
        cmp("event_cycle", cyc, e.at);
      end
    end
  task automatic tick_once(input logic [23:0] t, input logic wrap, input bit counts);
    @(negedge clk);
    if (counts) q.push_back('{t, wrap, 1'b0, cyc + SS + 1});
    tick = 1'b1;
    repeat (4) @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic do_load(input logic [23:0] v, input bit ok, input logic [23:0] want);
    @(negedge clk);
    load = 1'b1;
    load_value = v;
    if (!ok) q.push_back('{want, 1'b0, 1'b1, cyc + 1});
    @(negedge clk);
    load = 1'b0;
    cmp("load_value", {8'd0, now}, {8'd0, want});
  endtask
  task automatic drain();
    for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
    cmp("queue_drained", q.size(), 32'd0);
  endtask
  initial begin
    tick = 1'b1;
    run = 1'b1;
    repeat (3) @(negedge clk);
    cmp("reset_time", {8'd0, now}, 32'd0);
    cmp("reset_pulses", {29'd0, o_sec_pulse, o_day_wrap, o_load_err}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    cmp("no_count_high_at_reset", {8'd0, now}, 32'd0);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    tick_once(24'h000001, 1'b0, 1'b1);
    drain();
    do_load(24'h235958, 1'b1, 24'h235958);
    tick_once(24'h235959, 1'b0, 1'b1);
    tick_once(24'h000000, 1'b1, 1'b1);
    drain();
    do_load(24'h095959, 1'b1, 24'h095959);
    tick_once(24'h100000, 1'b0, 1'b1);
    do_load(24'h000009, 1'b1, 24'h000009);
    tick_once(24'h000010, 1'b0, 1'b1);
    drain();
    run = 1'b0;
    repeat (3) tick_once(24'h000010, 1'b0, 1'b0);
    cmp("paused_time", {8'd0, now}, {8'd0, 24'h000010});
    run = 1'b1;
    tick_once(24'h000011, 1'b0, 1'b1);
    drain();
    @(negedge clk);
    tick = 1'b1;
    repeat (SS) @(negedge clk);
    load = 1'b1;
    load_value = 24'h120000;
    @(negedge clk);
    load = 1'b0;
    cmp("load_beats_tick", {8'd0, now}, {8'd0, 24'h120000});
    repeat (4) @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    cmp("load_beats_tick_hold", {8'd0, now}, {8'd0, 24'h120000});
    do_load(24'h126000, 1'b0, 24'h120000);
    do_load(24'h0A0000, 1'b0, 24'h120000);
    do_load(24'h240000, 1'b0, 24'h120000);
    drain();
    do_load(24'h010203, 1'b1, 24'h010203);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("mid_reset_time", {8'd0, now}, 32'd0);
    repeat (8) @(negedge clk);
    cmp("mid_reset_no_count", {8'd0, now}, 32'd0);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    tick_once(24'h000001, 1'b0, 1'b1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
